// File: rtl/shift_counter_pkg.sv
// Shared constants, step-action encoding and start-state helper for the
// shift/ring/Johnson counter family.
package shift_counter_pkg;

   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   localparam int MAX_WIDTH = 64;

   typedef enum logic [2:0] {
      ACT_RESET   = 3'd0,
      ACT_MODE    = 3'd1,
      ACT_LOAD    = 3'd2,
      ACT_CORRECT = 3'd3,
      ACT_STEP    = 3'd4,
      ACT_HOLD    = 3'd5
   } step_action_e;

   // Ring starts with only the MSB set; Johnson starts from all zeros.
   // Callers truncate the result to their own width.
   function automatic logic [MAX_WIDTH-1:0] start_state(input int width, input logic mode);
      logic [MAX_WIDTH-1:0] s;
      s = '0;
      if (mode == MODE_RING) begin
         s[width-1] = 1'b1;
      end
      return s;
   endfunction

endpackage

// File: rtl/shift_counter_check.sv
// Combinational legality checker: one-hot for ring mode, thermometer code
// (either orientation, including all-0/all-1) for Johnson mode.
module shift_counter_check
   import shift_counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] q,
   input  logic             mode,
   output logic             illegal
);

   logic [WIDTH-1:0] inv;
   logic             low_ones;
   logic             high_ones;

   // x & (x+1) is zero exactly when x is a run of ones anchored at bit 0.
   always_comb begin
      inv       = ~q;
      low_ones  = ((q & (q + WIDTH'(1))) == '0);
      high_ones = ((inv & (inv + WIDTH'(1))) == '0);
      if (mode == MODE_JOHNSON) begin
         illegal = !(low_ones || high_ones);
      end else begin
         illegal = !$onehot(q);
      end
   end

endmodule

// File: rtl/shift_ring_counter.sv
// Parametrised ring / Johnson counter with direction control, seed load,
// wrap pulse, illegal-state flag and optional self-correction.
module shift_ring_counter
   import shift_counter_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter bit AUTO_CORRECT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             wrap,
   output logic             illegal
);

   localparam logic [WIDTH-1:0] START_RING    = WIDTH'(start_state(WIDTH, MODE_RING));
   localparam logic [WIDTH-1:0] START_JOHNSON = WIDTH'(start_state(WIDTH, MODE_JOHNSON));

   logic             mode_q;
   logic             shifted_out;
   logic             fb;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] start_new;
   logic [WIDTH-1:0] start_cur;
   step_action_e     action;

   shift_counter_check #(
      .WIDTH (WIDTH)
   ) u_check (
      .q       (q),
      .mode    (mode_q),
      .illegal (illegal)
   );

   always_comb begin
      shifted_out = (dir == DIR_LEFT) ? q[WIDTH-1] : q[0];
      fb          = (mode_q == MODE_JOHNSON) ? ~shifted_out : shifted_out;
      if (dir == DIR_LEFT) begin
         shifted = {q[WIDTH-2:0], fb};
      end else begin
         shifted = {fb, q[WIDTH-1:1]};
      end

      // start_new follows the incoming mode (reset / mode change);
      // start_cur follows the registered mode (correction / wrap compare).
      start_new = (mode == MODE_JOHNSON)   ? START_JOHNSON : START_RING;
      start_cur = (mode_q == MODE_JOHNSON) ? START_JOHNSON : START_RING;

      if (rst) begin
         action = ACT_RESET;
      end else if (mode != mode_q) begin
         action = ACT_MODE;
      end else if (load) begin
         action = ACT_LOAD;
      end else if (en && illegal && AUTO_CORRECT) begin
         action = ACT_CORRECT;
      end else if (en) begin
         action = ACT_STEP;
      end else begin
         action = ACT_HOLD;
      end
   end

   always_ff @(posedge clk) begin
      case (action)
         ACT_RESET, ACT_MODE: begin
            q      <= start_new;
            mode_q <= mode;
            wrap   <= 1'b0;
         end
         ACT_LOAD: begin
            q    <= load_val;
            wrap <= 1'b0;
         end
         ACT_CORRECT: begin
            q    <= start_cur;
            wrap <= 1'b0;
         end
         ACT_STEP: begin
            q    <= shifted;
            wrap <= (shifted == start_cur);
         end
         default: begin
            wrap <= 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_ring_counter.sv
// Self-checking bench: three counters (W4 corrected, W4 uncorrected, W8
// corrected) share control inputs and are compared every cycle to an
// integer-arithmetic reference, plus directed expectations.
module tb_shift_ring_counter;

   logic       clk = 1'b0;
   logic       rst, en, mode, dir, load;
   logic [7:0] load_val8;

   logic [3:0] q_a, q_b;
   logic [7:0] q_c;
   logic       wrap_a, wrap_b, wrap_c;
   logic       ill_a, ill_b, ill_c;
   logic       ref_ill_a;

   int n_tests = 0;
   int n_fail  = 0;

   int m_q[3];
   int m_mode[3];
   int m_wrap[3];
   int m_w[3]  = '{4, 4, 8};
   int m_ac[3] = '{1, 0, 1};

   always #5 clk = ~clk;

   shift_ring_counter #(.WIDTH(4), .AUTO_CORRECT(1'b1)) dut_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
      .load_val(load_val8[3:0]), .q(q_a), .wrap(wrap_a), .illegal(ill_a));

   shift_ring_counter #(.WIDTH(4), .AUTO_CORRECT(1'b0)) dut_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
      .load_val(load_val8[3:0]), .q(q_b), .wrap(wrap_b), .illegal(ill_b));

   shift_ring_counter #(.WIDTH(8), .AUTO_CORRECT(1'b1)) dut_c (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
      .load_val(load_val8), .q(q_c), .wrap(wrap_c), .illegal(ill_c));

   logic ref_mode_a;
   shift_counter_check #(.WIDTH(4)) ref_chk (
      .q(q_a), .mode(ref_mode_a), .illegal(ref_ill_a));

   function automatic int m_start(int w, int m);
      return (m != 0) ? 0 : (1 << (w - 1));
   endfunction

   function automatic bit m_legal(int q, int w, int m);
      int mask = (1 << w) - 1;
      if (m == 0) return ($countones(q) == 1);
      for (int k = 0; k <= w; k++) begin
         int t = (1 << k) - 1;
         if (q == t || q == (mask ^ t)) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void m_step(int i);
      int w    = m_w[i];
      int mask = (1 << w) - 1;
      int out_bit, fb;
      if (rst) begin
         m_q[i] = m_start(w, int'(mode)); m_mode[i] = int'(mode); m_wrap[i] = 0;
      end else if (int'(mode) != m_mode[i]) begin
         m_q[i] = m_start(w, int'(mode)); m_mode[i] = int'(mode); m_wrap[i] = 0;
      end else if (load) begin
         m_q[i] = int'(load_val8) & mask; m_wrap[i] = 0;
      end else if (en && m_ac[i] != 0 && !m_legal(m_q[i], w, m_mode[i])) begin
         m_q[i] = m_start(w, m_mode[i]); m_wrap[i] = 0;
      end else if (en) begin
         if (!dir) begin
            out_bit = (m_q[i] >> (w - 1)) & 1;
            fb      = (m_mode[i] != 0) ? 1 - out_bit : out_bit;
            m_q[i]  = ((m_q[i] * 2) & mask) | fb;
         end else begin
            out_bit = m_q[i] & 1;
            fb      = (m_mode[i] != 0) ? 1 - out_bit : out_bit;
            m_q[i]  = (m_q[i] / 2) | (fb << (w - 1));
         end
         m_wrap[i] = (m_q[i] == m_start(w, m_mode[i])) ? 1 : 0;
      end else begin
         m_wrap[i] = 0;
      end
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_models();
      chk("a_q",    {4'h0, q_a},    8'(m_q[0]));
      chk("a_wrap", {7'h0, wrap_a}, 8'(m_wrap[0]));
      chk("a_ill",  {7'h0, ill_a},  8'(!m_legal(m_q[0], 4, m_mode[0])));
      chk("b_q",    {4'h0, q_b},    8'(m_q[1]));
      chk("b_wrap", {7'h0, wrap_b}, 8'(m_wrap[1]));
      chk("b_ill",  {7'h0, ill_b},  8'(!m_legal(m_q[1], 4, m_mode[1])));
      chk("c_q",    q_c,            8'(m_q[2]));
      chk("c_wrap", {7'h0, wrap_c}, 8'(m_wrap[2]));
      chk("c_ill",  {7'h0, ill_c},  8'(!m_legal(m_q[2], 8, m_mode[2])));
      chk("ref_chk", {7'h0, ref_ill_a}, 8'(!m_legal(m_q[0], 4, m_mode[0])));
   endtask

   // One clock: inputs already set, advance models at the edge, check #1 later.
   task automatic cycle();
      @(posedge clk);
      for (int i = 0; i < 3; i++) m_step(i);
      ref_mode_a = m_mode[0][0];
      #1;
      check_models();
   endtask

   task automatic set_in(input logic r, input logic e, input logic m, input logic d,
                         input logic l, input logic [7:0] lv);
      rst = r; en = e; mode = m; dir = d; load = l; load_val8 = lv;
   endtask

   int ring_seq[8]  = '{1, 2, 4, 8, 1, 2, 4, 8};
   int john_seq[16] = '{8, 12, 14, 15, 7, 3, 1, 0, 8, 12, 14, 15, 7, 3, 1, 0};

   initial begin
      ref_mode_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m_q[i] = 0; m_mode[i] = 0; m_wrap[i] = 0;
      end

      // Reset into ring mode
      set_in(1, 0, 0, 0, 0, 8'h00);
      cycle();
      chk("rst_q_a", {4'h0, q_a}, 8'h08);
      chk("rst_q_c", q_c, 8'h80);
      chk("rst_wrap", {7'h0, wrap_a}, 8'h00);
      chk("rst_ill", {7'h0, ill_a}, 8'h00);

      // Ring, left, 8 steps
      set_in(0, 1, 0, 0, 0, 8'h00);
      for (int k = 0; k < 8; k++) begin
         cycle();
         chk("ring_q", {4'h0, q_a}, 8'(ring_seq[k]));
         chk("ring_wrap", {7'h0, wrap_a}, (ring_seq[k] == 8) ? 8'h01 : 8'h00);
      end

      // Switch to Johnson (en ignored on the switch cycle), then right for 16
      set_in(0, 1, 1, 1, 0, 8'h00);
      cycle();
      chk("jsw_q", {4'h0, q_a}, 8'h00);
      chk("jsw_wrap", {7'h0, wrap_a}, 8'h00);
      for (int k = 0; k < 16; k++) begin
         cycle();
         chk("john_q", {4'h0, q_a}, 8'(john_seq[k]));
         chk("john_wrap", {7'h0, wrap_a}, (john_seq[k] == 0) ? 8'h01 : 8'h00);
      end

      // Correction vs. no correction from 0110 in ring mode
      set_in(0, 0, 0, 0, 0, 8'h00);
      cycle();
      set_in(0, 0, 0, 0, 1, 8'h06);
      cycle();
      chk("ld_ill_a", {7'h0, ill_a}, 8'h01);
      chk("ld_ill_b", {7'h0, ill_b}, 8'h01);
      set_in(0, 1, 0, 0, 0, 8'h00);
      cycle();
      chk("corr_q_a", {4'h0, q_a}, 8'h08);
      chk("corr_wrap_a", {7'h0, wrap_a}, 8'h00);
      chk("corr_ill_a", {7'h0, ill_a}, 8'h00);
      chk("nocorr_q_b", {4'h0, q_b}, 8'h0C);
      chk("nocorr_ill_b", {7'h0, ill_b}, 8'h01);

      // Mode switch beats a same-cycle load
      set_in(0, 0, 0, 0, 1, 8'h02);
      cycle();
      chk("ms_pre_q", {4'h0, q_a}, 8'h02);
      set_in(0, 0, 1, 0, 1, 8'h0F);
      cycle();
      chk("ms_q", {4'h0, q_a}, 8'h00);
      chk("ms_wrap", {7'h0, wrap_a}, 8'h00);
      set_in(0, 1, 1, 0, 0, 8'h00);
      cycle();
      chk("ms_step", {4'h0, q_a}, 8'h01);

      // Reset overrides en on the 8-bit Johnson counter
      set_in(0, 0, 1, 0, 1, 8'h0F);
      cycle();
      chk("rp_pre_c", q_c, 8'h0F);
      set_in(1, 1, 1, 0, 0, 8'h00);
      cycle();
      chk("rp_q_c", q_c, 8'h00);
      chk("rp_wrap_c", {7'h0, wrap_c}, 8'h00);
      set_in(1, 1, 0, 0, 0, 8'h00);
      cycle();
      chk("rp_ring_c", q_c, 8'h80);

      // Hold, then flip direction
      set_in(0, 1, 0, 0, 0, 8'h00);
      for (int k = 0; k < 3; k++) cycle();
      chk("hd_pre", {4'h0, q_a}, 8'h04);
      set_in(0, 0, 0, 0, 0, 8'h00);
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("hold_q", {4'h0, q_a}, 8'h04);
      end
      set_in(0, 1, 0, 1, 0, 8'h00);
      cycle();
      chk("flip_q1", {4'h0, q_a}, 8'h02);
      cycle();
      chk("flip_q2", {4'h0, q_a}, 8'h01);
      cycle();
      chk("flip_q3", {4'h0, q_a}, 8'h08);
      chk("flip_wrap", {7'h0, wrap_a}, 8'h01);

      // Randomized phase against the reference model
      for (int k = 0; k < 400; k++) begin
         rst       = ($urandom_range(39) == 0);
         if ($urandom_range(19) == 0) mode = ~mode;
         load      = ($urandom_range(5) == 0);
         en        = ($urandom_range(3) != 0);
         if ($urandom_range(7) == 0) dir = ~dir;
         load_val8 = 8'($urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
